// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter: merges single-cycle ALU results with queued long-latency results.
// Tracks a pending-destination mask for hazard stalls. Grant is combinational; FIFO pops and pushes take effect at the edge.
module regfile_wb_arbiter #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_alu_wren,
  input  logic [4:0]               i_alu_rd,
  input  logic [31:0]              i_alu_data,
  output logic                     o_alu_stall,
  input  logic                     i_ll_valid,
  output logic                     o_ll_ready,
  input  logic [4:0]               i_ll_rd,
  input  logic [31:0]              i_ll_data,
  input  logic                     i_issue_valid,
  input  logic [4:0]               i_issue_rd,
  output logic                     o_issue_ready,
  input  logic [4:0]               i_rs1_addr,
  input  logic [4:0]               i_rs2_addr,
  output logic                     o_rs1_busy,
  output logic                     o_rs2_busy,
  output logic [4:0]               o_rd_addr,
  output logic [31:0]              o_rd_data,
  output logic                     o_rd_wren,
  output logic [$clog2(DEPTH):0]   o_ll_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [4:0]    rd_mem_q   [DEPTH];
  logic [31:0]   data_mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] count_q, count_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [31:0]   pend_q, pend_d;

  logic empty, full, alu_req, alu_block, force_ll, alu_win, pop, push, issue_acc;
  logic [4:0]  head_rd;
  logic [31:0] head_data;

  always_comb begin
    empty     = (count_q == '0);
    full      = (count_q == CW'(DEPTH));
    head_rd   = rd_mem_q[rptr_q];
    head_data = data_mem_q[rptr_q];
    // Gating with reset keeps the write port and stall quiet while in reset.
    alu_req   = i_reset && i_alu_wren && (i_alu_rd != 5'd0);
    alu_block = alu_req && pend_q[i_alu_rd];
    force_ll  = !empty && (starve_q == SW'(STARVE_LIMIT));
    alu_win   = alu_req && !alu_block && !force_ll;
    pop       = !alu_win && !empty;
    push      = i_ll_valid && !full;

    o_ll_ready    = !full;
    o_alu_stall   = alu_req && (alu_block || force_ll);
    o_issue_ready = !(i_issue_valid && pend_q[i_issue_rd]);
    issue_acc     = i_reset && i_issue_valid && o_issue_ready && (i_issue_rd != 5'd0);
    o_rs1_busy    = pend_q[i_rs1_addr];
    o_rs2_busy    = pend_q[i_rs2_addr];
    o_ll_count    = count_q;

    o_rd_wren = 1'b0;
    o_rd_addr = 5'd0;
    o_rd_data = 32'd0;
    if (alu_win) begin
      o_rd_wren = 1'b1;
      o_rd_addr = i_alu_rd;
      o_rd_data = i_alu_data;
    end else if (pop) begin
      o_rd_wren = (head_rd != 5'd0);
      o_rd_addr = head_rd;
      o_rd_data = head_data;
    end

    // Set after clear so a same-cycle issue to the retiring rd stays pending.
    pend_d = pend_q;
    if (pop)       pend_d[head_rd]    = 1'b0;
    if (issue_acc) pend_d[i_issue_rd] = 1'b1;
    pend_d[0] = 1'b0;

    count_d = count_q + CW'(push) - CW'(pop);

    starve_d = starve_q;
    if (empty || pop)
      starve_d = '0;
    else if (alu_win && (starve_q != SW'(STARVE_LIMIT)))
      starve_d = starve_q + SW'(1);
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      starve_q <= '0;
      pend_q   <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + AW'(1);
      if (pop)  rptr_q <= rptr_q + AW'(1);
      count_q  <= count_d;
      starve_q <= starve_d;
      pend_q   <= pend_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) begin
      rd_mem_q[wptr_q]   <= i_ll_rd;
      data_mem_q[wptr_q] <= i_ll_data;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: table-driven ALU vectors plus scoreboarded long-latency sequences.
module tb_regfile_wb_arbiter;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_alu_wren;
  logic [4:0]  i_alu_rd;
  logic [31:0] i_alu_data;
  logic        o_alu_stall;
  logic        i_ll_valid;
  logic        o_ll_ready;
  logic [4:0]  i_ll_rd;
  logic [31:0] i_ll_data;
  logic        i_issue_valid;
  logic [4:0]  i_issue_rd;
  logic        o_issue_ready;
  logic [4:0]  i_rs1_addr;
  logic [4:0]  i_rs2_addr;
  logic        o_rs1_busy;
  logic        o_rs2_busy;
  logic [4:0]  o_rd_addr;
  logic [31:0] o_rd_data;
  logic        o_rd_wren;
  logic [1:0]  o_ll_count;

  always #5 i_clk = ~i_clk;

  regfile_wb_arbiter #(.DEPTH(2), .STARVE_LIMIT(4)) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_alu_wren(i_alu_wren), .i_alu_rd(i_alu_rd), .i_alu_data(i_alu_data), .o_alu_stall(o_alu_stall),
    .i_ll_valid(i_ll_valid), .o_ll_ready(o_ll_ready), .i_ll_rd(i_ll_rd), .i_ll_data(i_ll_data),
    .i_issue_valid(i_issue_valid), .i_issue_rd(i_issue_rd), .o_issue_ready(o_issue_ready),
    .i_rs1_addr(i_rs1_addr), .i_rs2_addr(i_rs2_addr), .o_rs1_busy(o_rs1_busy), .o_rs2_busy(o_rs2_busy),
    .o_rd_addr(o_rd_addr), .o_rd_data(o_rd_data), .o_rd_wren(o_rd_wren), .o_ll_count(o_ll_count)
  );

  typedef struct {
    logic        wren;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        exp_wren;
    logic [4:0]  exp_addr;
    logic [31:0] exp_data;
  } vec_t;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  vec_t vecs[4];
  ent_t ll_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // One clock: check stall, check the write port against ALU inputs or the
  // long-latency scoreboard, record accepted pushes, then advance past the edge.
  task automatic tick(input logic exp_alu, input logic exp_stall);
    #1;
    chk("alu_stall", 32'(o_alu_stall), 32'(exp_stall));
    if (exp_alu) begin
      chk("alu_wren", 32'(o_rd_wren), 32'd1);
      chk("alu_addr", 32'(o_rd_addr), 32'(i_alu_rd));
      chk("alu_data", o_rd_data, i_alu_data);
    end else if (o_rd_wren) begin
      if (ll_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write addr=%0d data=%0h required=no write", o_rd_addr, o_rd_data);
      end else begin
        ent_t e;
        e = ll_q.pop_front();
        chk("ll_addr", 32'(o_rd_addr), 32'(e.rd));
        chk("ll_data", o_rd_data, e.data);
      end
    end
    if (i_ll_valid && o_ll_ready) ll_q.push_back('{i_ll_rd, i_ll_data});
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    vecs[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b1, 5'd5,  32'hDEADBEEF};
    vecs[1] = '{1'b1, 5'd0,  32'h55555555, 1'b0, 5'd0,  32'h0};
    vecs[2] = '{1'b0, 5'd3,  32'h33333333, 1'b0, 5'd0,  32'h0};
    vecs[3] = '{1'b1, 5'd31, 32'h00000001, 1'b1, 5'd31, 32'h00000001};

    i_reset = 1'b0;
    i_alu_wren = 1'b1; i_alu_rd = 5'd5; i_alu_data = 32'h1;
    i_ll_valid = 1'b0; i_ll_rd = 5'd0; i_ll_data = 32'd0;
    i_issue_valid = 1'b1; i_issue_rd = 5'd4;
    i_rs1_addr = 5'd4; i_rs2_addr = 5'd0;
    #2;
    chk("rst_wren", 32'(o_rd_wren), 32'd0);
    chk("rst_stall", 32'(o_alu_stall), 32'd0);
    chk("rst_ll_ready", 32'(o_ll_ready), 32'd1);
    chk("rst_issue_ready", 32'(o_issue_ready), 32'd1);
    chk("rst_count", 32'(o_ll_count), 32'd0);
    chk("rst_busy", 32'({o_rs1_busy, o_rs2_busy}), 32'd0);
    repeat (2) @(posedge i_clk);
    #1;
    chk("rst_busy_held", 32'(o_rs1_busy), 32'd0);
    i_reset = 1'b1;
    i_alu_wren = 1'b0;
    i_issue_valid = 1'b0;

    // Single-cycle ALU writes
    for (int i = 0; i < 4; i++) begin
      i_alu_wren = vecs[i].wren;
      i_alu_rd   = vecs[i].rd;
      i_alu_data = vecs[i].data;
      #1;
      chk("vec_wren", 32'(o_rd_wren), 32'(vecs[i].exp_wren));
      chk("vec_addr", 32'(o_rd_addr), 32'(vecs[i].exp_addr));
      chk("vec_data", o_rd_data, vecs[i].exp_data);
      tick(vecs[i].exp_wren, 1'b0);
    end
    i_alu_wren = 1'b0;

    // Issue rd=7, its result is queued, written a cycle later, busy clears at that edge
    i_issue_valid = 1'b1; i_issue_rd = 5'd7; i_rs1_addr = 5'd7;
    #1;
    chk("issue7_ready", 32'(o_issue_ready), 32'd1);
    tick(1'b0, 1'b0);
    i_issue_valid = 1'b0;
    chk("rs1_busy7", 32'(o_rs1_busy), 32'd1);
    i_ll_valid = 1'b1; i_ll_rd = 5'd7; i_ll_data = 32'h12345678;
    #1;
    chk("no_writethrough", 32'(o_rd_wren), 32'd0);
    tick(1'b0, 1'b0);
    i_ll_valid = 1'b0;
    chk("count_one", 32'(o_ll_count), 32'd1);
    chk("busy7_until_write", 32'(o_rs1_busy), 32'd1);
    tick(1'b0, 1'b0);
    chk("busy7_cleared", 32'(o_rs1_busy), 32'd0);
    chk("count_zero", 32'(o_ll_count), 32'd0);

    // WAW on rd=9: ALU stalls until the long-latency result retires
    i_issue_valid = 1'b1; i_issue_rd = 5'd9;
    tick(1'b0, 1'b0);
    i_alu_wren = 1'b1; i_alu_rd = 5'd9; i_alu_data = 32'h99;
    #1;
    chk("waw_issue_ready", 32'(o_issue_ready), 32'd0);
    chk("waw_wren", 32'(o_rd_wren), 32'd0);
    tick(1'b0, 1'b1);
    i_issue_valid = 1'b0;
    i_ll_valid = 1'b1; i_ll_rd = 5'd9; i_ll_data = 32'h9999;
    tick(1'b0, 1'b1);
    i_ll_valid = 1'b0;
    tick(1'b0, 1'b1);
    tick(1'b1, 1'b0);
    i_alu_wren = 1'b0;
    chk("waw_drained", 32'(ll_q.size()), 32'd0);

    // Starvation guard: ALU writes every cycle with two queued results
    i_issue_valid = 1'b1; i_issue_rd = 5'd10;
    tick(1'b0, 1'b0);
    i_issue_rd = 5'd11;
    tick(1'b0, 1'b0);
    i_issue_valid = 1'b0;
    i_rs1_addr = 5'd10; i_rs2_addr = 5'd11;
    for (int c = 1; c <= 11; c++) begin
      i_alu_wren = 1'b1; i_alu_rd = 5'd1; i_alu_data = 32'h100 + 32'(c);
      i_ll_valid = (c <= 2);
      i_ll_rd    = (c == 1) ? 5'd10 : 5'd11;
      i_ll_data  = (c == 1) ? 32'hA0 : 32'hB0;
      #1;
      if (c >= 3 && c <= 6) chk("full_ready", 32'(o_ll_ready), 32'd0);
      if (c == 7) chk("ready_after_pop", 32'(o_ll_ready), 32'd1);
      tick(!(c == 6 || c == 11), (c == 6 || c == 11));
      if (c == 6) begin
        chk("busy10_clear", 32'(o_rs1_busy), 32'd0);
        chk("busy11_held", 32'(o_rs2_busy), 32'd1);
      end
    end
    i_alu_wren = 1'b0; i_ll_valid = 1'b0;
    chk("starve_count", 32'(o_ll_count), 32'd0);
    chk("starve_drained", 32'(ll_q.size()), 32'd0);

    // Source holds a result while full; order A, B, C preserved
    i_alu_wren = 1'b1; i_alu_rd = 5'd2; i_alu_data = 32'h2;
    i_ll_valid = 1'b1; i_ll_rd = 5'd12; i_ll_data = 32'hA;
    tick(1'b1, 1'b0);
    i_ll_rd = 5'd13; i_ll_data = 32'hB;
    tick(1'b1, 1'b0);
    chk("full_count", 32'(o_ll_count), 32'd2);
    i_alu_wren = 1'b0;
    i_ll_rd = 5'd14; i_ll_data = 32'hC;
    #1;
    chk("held_ready", 32'(o_ll_ready), 32'd0);
    tick(1'b0, 1'b0);
    chk("count_after_pop", 32'(o_ll_count), 32'd1);
    #1;
    chk("ready_reopen", 32'(o_ll_ready), 32'd1);
    tick(1'b0, 1'b0);
    chk("count_push_pop", 32'(o_ll_count), 32'd1);
    i_ll_valid = 1'b0;
    tick(1'b0, 1'b0);
    chk("order_count", 32'(o_ll_count), 32'd0);
    chk("order_drained", 32'(ll_q.size()), 32'd0);

    // Reset mid-operation with queued entries and pending bits
    i_issue_valid = 1'b1; i_issue_rd = 5'd20;
    tick(1'b0, 1'b0);
    i_issue_rd = 5'd21;
    tick(1'b0, 1'b0);
    i_issue_valid = 1'b0;
    i_rs1_addr = 5'd20; i_rs2_addr = 5'd21;
    i_alu_wren = 1'b1; i_alu_rd = 5'd3; i_alu_data = 32'h3;
    i_ll_valid = 1'b1; i_ll_rd = 5'd20; i_ll_data = 32'h20;
    tick(1'b1, 1'b0);
    i_ll_rd = 5'd21; i_ll_data = 32'h21;
    tick(1'b1, 1'b0);
    i_alu_wren = 1'b0; i_ll_valid = 1'b0;
    chk("pre_rst_count", 32'(o_ll_count), 32'd2);
    chk("pre_rst_busy", 32'({o_rs1_busy, o_rs2_busy}), 32'd3);
    i_reset = 1'b0;
    #1;
    chk("mid_rst_wren", 32'(o_rd_wren), 32'd0);
    @(posedge i_clk);
    #1;
    i_reset = 1'b1;
    ll_q.delete();
    tick(1'b0, 1'b0);
    chk("post_rst_count", 32'(o_ll_count), 32'd0);
    chk("post_rst_busy", 32'({o_rs1_busy, o_rs2_busy}), 32'd0);
    #1;
    chk("post_rst_wren", 32'(o_rd_wren), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
